pet_state_ctrl: RTL and testbench
=================================

# pet_state_ctrl

Behaviour controller between the sensor front-ends (gyro, touch, sonic, joystick) and the LCD screen driver. It converts the sensor level flags and the `go` pulse into a pet state machine with a saturating mood score and a menu cursor. It presents a registered scene code plus a one-cycle scene-change strobe, which the screen stage uses to select and redraw artwork.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per timing tick (1 s at 100 MHz).
- `IDLE_TIMEOUT`, default 30: ticks without any input edge in IDLE before entering SLEEP.
- `HAPPY_TICKS`, default 3: dwell ticks in HAPPY and in FEED.
- `DECAY_TICKS`, default 10: mood decay period in ticks; used only with `PET_MOOD_DECAY_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `go` in 1: single-cycle start pulse.
- `awaking`, `touched`, `expecting`, `petting` in 1 each: sensor level flags.
- `pressed`, `up`, `down`, `left`, `right` in 1 each: joystick level flags.
- `scene` out 3: current state code. SLEEP=0, IDLE=1, HAPPY=2, EXPECT=3, MENU=4, FEED=5.
- `mood` out 4: saturating mood score, 0..15.
- `cursor` out 2: menu cursor, 0..3.
- `scene_upd` out 1: one-cycle pulse, high in the first cycle a new `scene` value is visible.

## Operation
- **Edge detection.** Each level input (all except `go`) has a previous-value register; rise = in & ~prev. Previous registers reset to 0, so an input already high at reset counts as a rise in the first cycle after reset. `expecting` also has a fall detector.
- **Tick timer.** Counter runs 0..TICK_DIV-1 and emits a one-cycle tick at the wrap. It restarts at 0 on every state change, so a dwell of N ticks lasts exactly N*TICK_DIV cycles.
- **Mood arithmetic.** Mood is 5-bit internally and clamped to 0..15; +2 at mood 14 gives 15, -1 at mood 0 gives 0.
- **SLEEP:** `awaking` rise or `go` -> IDLE.
- **IDLE:** priority order, first match wins:
  - `pressed` rise -> MENU, cursor=0.
  - `touched` or `petting` rise -> HAPPY, mood+2.
  - `expecting` high (level) -> EXPECT.
  - Idle tick count reaches IDLE_TIMEOUT -> SLEEP.
  - The idle count clears on any rise of any input.
- **HAPPY:** after HAPPY_TICKS ticks -> IDLE. A `touched` or `petting` rise restarts the dwell and adds mood+1.
- **EXPECT:** `petting` rise -> HAPPY, mood+2. Otherwise, `expecting` fall -> IDLE, mood-1. If both occur in the same cycle, `petting` wins.
- **MENU:**
  - `up` rise: cursor-1, wrapping 0->3. `down` rise: cursor+1, wrapping 3->0. If `up` and `down` rise together, cursor is unchanged.
  - `left` rise -> IDLE (cancel).
  - `pressed` rise selects by cursor: 0 -> FEED (mood+4), 1 -> HAPPY (mood+2), 2 -> SLEEP, 3 -> IDLE.
  - If `pressed` and `left` rise together, `pressed` wins.
- **FEED:** after HAPPY_TICKS ticks -> IDLE; inputs are ignored.
- **`go` pulse:** in any state other than SLEEP, `go` has no effect.
- **Reset mid-operation:** all state returns to reset values on the next edge, regardless of any pending transition.

## Timing
- Reset values: scene=0 (SLEEP), mood=8, cursor=0, scene_upd=0, tick counter=0, idle count=0.
- All outputs are registered. An input rise sampled at edge k updates `scene`, `mood` and `cursor` at edge k; the new values are visible in cycle k+1. Latency is 1 cycle from the input level being high.
- `scene_upd` is high for exactly the one cycle after each state-register change, and never when the state is unchanged.
- A timed exit (HAPPY, FEED, IDLE timeout) occurs on the edge that samples the final tick.

## Configuration
- `PET_MOOD_DECAY_EN` defined: in IDLE, each DECAY_TICKS consecutive ticks without an input rise decrement mood by 1, saturating at 0. The decay count clears on any rise and on leaving IDLE.
- Not defined: mood changes only on the event rules above, and the decay counter logic is absent.

## Test plan
Bench parameters: TICK_DIV=4, IDLE_TIMEOUT=5, HAPPY_TICKS=2, DECAY_TICKS=3.
- Reset, then `go` pulse -> scene 0->1, `scene_upd` high for 1 cycle, mood=8.
- IDLE with no input for 20 cycles -> scene=0 exactly 20 cycles after entry.
  - With `PET_MOOD_DECAY_EN`: mood=7 at cycle 12.
- IDLE, `touched` rises -> scene=2 and mood=10 next cycle.
  - `petting` rise 5 cycles later -> mood=11 and the dwell restarts; IDLE 8 cycles after that rise.
- IDLE, `expecting` held high -> EXPECT; then `expecting` low -> IDLE, mood=7.
  - Repeat 9 times -> mood saturates at 0.
- MENU, `up` rise from cursor 0 -> cursor=3; `down` rise -> cursor=0.
  - `pressed` rise -> FEED, mood 14->15 (saturated); IDLE after 8 cycles.
- `rst` asserted in HAPPY while `touched` rises in the same cycle -> scene=0, mood=8, `scene_upd`=0 next cycle.

Source files
------------

// File: rtl/pet_state_ctrl.sv
// Pet behaviour FSM: sensor/joystick edges -> scene code, saturating mood, menu cursor.
// Optional build macro PET_MOOD_DECAY_EN enables slow mood decay while idle.
module pet_state_ctrl #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned IDLE_TIMEOUT = 30,
  parameter int unsigned HAPPY_TICKS  = 3,
  parameter int unsigned DECAY_TICKS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       awaking,
  input  logic       touched,
  input  logic       expecting,
  input  logic       petting,
  input  logic       pressed,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [2:0] scene,
  output logic [3:0] mood,
  output logic [1:0] cursor,
  output logic       scene_upd
);

  localparam int unsigned NLVL = 9;
  localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CMAX = (IDLE_TIMEOUT > HAPPY_TICKS)
                                 ? ((IDLE_TIMEOUT > DECAY_TICKS) ? IDLE_TIMEOUT : DECAY_TICKS)
                                 : ((HAPPY_TICKS > DECAY_TICKS) ? HAPPY_TICKS : DECAY_TICKS);
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam int unsigned I_AWK = 0;
  localparam int unsigned I_TCH = 1;
  localparam int unsigned I_EXP = 2;
  localparam int unsigned I_PET = 3;
  localparam int unsigned I_PRS = 4;
  localparam int unsigned I_UP  = 5;
  localparam int unsigned I_DN  = 6;
  localparam int unsigned I_LFT = 7;

  typedef enum logic [2:0] {
    ST_SLEEP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_HAPPY  = 3'd2,
    ST_EXPECT = 3'd3,
    ST_MENU   = 3'd4,
    ST_FEED   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      mood_q, mood_d;
  logic [1:0]      cursor_q, cursor_d;
  logic            upd_q;
  logic [NLVL-1:0] lvl, prev_q, rise;
  logic            any_rise, exp_fall;
  logic [TW-1:0]   tick_q;
  logic            tick_c;
  logic [CW-1:0]   cnt_q;
  logic            retrig, cnt_clr, restart_c;

  function automatic logic [3:0] mood_inc(input logic [3:0] m, input logic [2:0] d);
    logic [4:0] s;
    s = 5'(m) + 5'(d);
    return (s > 5'd15) ? 4'd15 : s[3:0];
  endfunction

  function automatic logic [3:0] mood_dec(input logic [3:0] m);
    return (m == 4'd0) ? 4'd0 : m - 4'd1;
  endfunction

  assign lvl      = {right, left, down, up, pressed, petting, expecting, touched, awaking};
  assign rise     = lvl & ~prev_q;
  assign any_rise = |rise;
  assign exp_fall = ~expecting & prev_q[I_EXP];
  assign tick_c   = (tick_q == TW'(TICK_DIV - 1));

  // cnt_q counts ticks since entry: dwell in HAPPY/FEED, quiet ticks in IDLE
  always_comb begin
    state_d  = state_q;
    mood_d   = mood_q;
    cursor_d = cursor_q;
    retrig   = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_SLEEP: begin
        if (rise[I_AWK] || go) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rise[I_PRS]) begin
          state_d  = ST_MENU;
          cursor_d = 2'd0;
        end else if (rise[I_TCH] || rise[I_PET]) begin
          state_d = ST_HAPPY;
          mood_d  = mood_inc(mood_q, 3'd2);
        end else if (expecting) begin
          state_d = ST_EXPECT;
        end else if (any_rise) begin
          cnt_clr = 1'b1;
        end else if (tick_c && cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
          state_d = ST_SLEEP;
        end
      end
      ST_HAPPY: begin
        if (rise[I_TCH] || rise[I_PET]) begin
          retrig = 1'b1;
          mood_d = mood_inc(mood_q, 3'd1);
        end else if (tick_c && cnt_q == CW'(HAPPY_TICKS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPECT: begin
        if (rise[I_PET]) begin
          state_d = ST_HAPPY;
          mood_d  = mood_inc(mood_q, 3'd2);
        end else if (exp_fall) begin
          state_d = ST_IDLE;
          mood_d  = mood_dec(mood_q);
        end
      end
      ST_MENU: begin
        if (rise[I_UP] && !rise[I_DN]) cursor_d = cursor_q - 2'd1;
        else if (rise[I_DN] && !rise[I_UP]) cursor_d = cursor_q + 2'd1;
        // selection uses the cursor as it stood before this cycle's moves
        if (rise[I_PRS]) begin
          case (cursor_q)
            2'd0: begin
              state_d = ST_FEED;
              mood_d  = mood_inc(mood_q, 3'd4);
            end
            2'd1: begin
              state_d = ST_HAPPY;
              mood_d  = mood_inc(mood_q, 3'd2);
            end
            2'd2:    state_d = ST_SLEEP;
            default: state_d = ST_IDLE;
          endcase
        end else if (rise[I_LFT]) begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (tick_c && cnt_q == CW'(HAPPY_TICKS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_SLEEP;
    endcase
  end

  assign restart_c = retrig || (state_d != state_q);

`ifdef PET_MOOD_DECAY_EN
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [3:0]    mood_nx;

  // Quiet-tick decay; only applies while remaining in IDLE
  always_comb begin
    dcnt_d  = dcnt_q;
    mood_nx = mood_d;
    if (state_q != ST_IDLE || state_d != ST_IDLE || any_rise) begin
      dcnt_d = '0;
    end else if (tick_c) begin
      if (dcnt_q == CW'(DECAY_TICKS - 1)) begin
        dcnt_d  = '0;
        mood_nx = mood_dec(mood_d);
      end else begin
        dcnt_d = dcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dcnt_q <= '0;
    else     dcnt_q <= dcnt_d;
  end
`else
  logic [3:0] mood_nx;
  assign mood_nx = mood_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SLEEP;
      mood_q   <= 4'd8;
      cursor_q <= 2'd0;
      upd_q    <= 1'b0;
      prev_q   <= '0;
      tick_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mood_q   <= mood_nx;
      cursor_q <= cursor_d;
      upd_q    <= (state_d != state_q);
      prev_q   <= lvl;
      tick_q   <= (restart_c || tick_c) ? '0 : tick_q + TW'(1);
      if (restart_c || cnt_clr) cnt_q <= '0;
      else if (tick_c)          cnt_q <= cnt_q + CW'(1);
    end
  end

  assign scene     = state_q;
  assign mood      = mood_q;
  assign cursor    = cursor_q;
  assign scene_upd = upd_q;

endmodule

// File: tb/tb_pet_state_ctrl.sv
// Bench for pet_state_ctrl: directed scenarios then random levels, against a cycle-count model.
module tb_pet_state_ctrl;

  localparam int TD = 4;
  localparam int IT = 5;
  localparam int HT = 2;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [8:0] lvl_in;
  logic [2:0] scene;
  logic [3:0] mood;
  logic [1:0] cursor;
  logic       scene_upd;

  always #5 clk = ~clk;

  pet_state_ctrl #(
    .TICK_DIV(TD), .IDLE_TIMEOUT(IT), .HAPPY_TICKS(HT), .DECAY_TICKS(DT)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .awaking(lvl_in[0]), .touched(lvl_in[1]), .expecting(lvl_in[2]), .petting(lvl_in[3]),
    .pressed(lvl_in[4]), .up(lvl_in[5]), .down(lvl_in[6]), .left(lvl_in[7]), .right(lvl_in[8]),
    .scene(scene), .mood(mood), .cursor(cursor), .scene_upd(scene_upd)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: age = cycles since entering scene (or HAPPY restart), quiet = ticks in IDLE since a rise
  int         m_scene, m_mood, m_cursor, m_upd, m_age, m_quiet;
  logic [8:0] m_prev;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 15) ? 15 : v);
  endfunction

  task automatic model_step();
    logic [8:0] r;
    int ns, nm, nc;
    bit tk, any, restart;
    if (rst) begin
      m_scene = 0; m_mood = 8; m_cursor = 0; m_upd = 0;
      m_age = 0; m_quiet = 0; m_prev = '0;
      return;
    end
    r   = lvl_in & ~m_prev;
    any = |r;
    tk  = (m_age % TD) == TD - 1;
    ns = m_scene; nm = m_mood; nc = m_cursor; restart = 0;
    case (m_scene)
      0: if (r[0] || go) ns = 1;
      1: begin
        if (r[4]) begin ns = 4; nc = 0; end
        else if (r[1] || r[3]) begin ns = 2; nm = clamp(nm + 2); end
        else if (lvl_in[2]) ns = 3;
        else if (!any && tk && m_quiet + 1 == IT) ns = 0;
      end
      2: begin
        if (r[1] || r[3]) begin restart = 1; nm = clamp(nm + 1); end
        else if (m_age + 1 == HT * TD) ns = 1;
      end
      3: begin
        if (r[3]) begin ns = 2; nm = clamp(nm + 2); end
        else if (!lvl_in[2] && m_prev[2]) begin ns = 1; nm = clamp(nm - 1); end
      end
      4: begin
        if (r[5] && !r[6]) nc = (m_cursor + 3) % 4;
        else if (r[6] && !r[5]) nc = (m_cursor + 1) % 4;
        if (r[4]) begin
          case (m_cursor)
            0: begin ns = 5; nm = clamp(nm + 4); end
            1: begin ns = 2; nm = clamp(nm + 2); end
            2: ns = 0;
            default: ns = 1;
          endcase
        end else if (r[7]) ns = 1;
      end
      5: if (m_age + 1 == HT * TD) ns = 1;
      default: ;
    endcase
    if (ns == 1 && m_scene == 1) begin
      if (any) m_quiet = 0;
      else if (tk) begin
        m_quiet++;
`ifdef PET_MOOD_DECAY_EN
        if (m_quiet % DT == 0) nm = clamp(nm - 1);
`endif
      end
    end else begin
      m_quiet = 0;
    end
    m_age    = (ns != m_scene || restart) ? 0 : m_age + 1;
    m_upd    = (ns != m_scene) ? 1 : 0;
    m_scene  = ns;
    m_mood   = nm;
    m_cursor = nc;
    m_prev   = lvl_in;
  endtask

  // Inputs are set at a falling edge; the DUT samples them on the next rising edge
  task automatic step();
    model_step();
    @(negedge clk);
    check("scene", int'(scene), m_scene);
    check("mood", int'(mood), m_mood);
    check("cursor", int'(cursor), m_cursor);
    check("scene_upd", int'(scene_upd), m_upd);
  endtask

  initial begin
    int quiet_left;
    int k;
    rst = 1'b1; go = 1'b0; lvl_in = '0;
    step(); step();
    check("rst_scene", int'(scene), 0);
    check("rst_mood", int'(mood), 8);
    check("rst_cursor", int'(cursor), 0);
    check("rst_upd", int'(scene_upd), 0);

    rst = 1'b0; go = 1'b1; step(); go = 1'b0;
    check("go_scene", int'(scene), 1);
    check("go_upd", int'(scene_upd), 1);
    check("go_mood", int'(mood), 8);
    step();
    check("upd_one_cycle", int'(scene_upd), 0);
    repeat (18) step();
    check("idle_hold_19", int'(scene), 1);
    step();
    check("idle_timeout_20", int'(scene), 0);
`ifdef PET_MOOD_DECAY_EN
    check("timeout_mood", int'(mood), 7);
`else
    check("timeout_mood", int'(mood), 8);
`endif

    go = 1'b1; step(); go = 1'b0;
    lvl_in[4] = 1'b1; step();
    check("menu_scene", int'(scene), 4);
    check("menu_cursor", int'(cursor), 0);
    lvl_in[4] = 1'b0; lvl_in[5] = 1'b1; step();
    check("up_wrap", int'(cursor), 3);
    lvl_in[5] = 1'b0; lvl_in[6] = 1'b1; step();
    check("down_wrap", int'(cursor), 0);
    lvl_in[6] = 1'b0; lvl_in[7] = 1'b1; step();
    check("left_cancel", int'(scene), 1);
    lvl_in[7] = 1'b0; lvl_in[1] = 1'b1; step();
    check("touch_happy", int'(scene), 2);
    lvl_in[1] = 1'b0; step();
    lvl_in[1] = 1'b1; rst = 1'b1; step();
    check("rst_mid_scene", int'(scene), 0);
    check("rst_mid_mood", int'(mood), 8);
    check("rst_mid_upd", int'(scene_upd), 0);
    rst = 1'b0; lvl_in = '0;

    quiet_left = 0;
    for (int c = 0; c < 4000; c++) begin
      go  = 1'b0;
      rst = 1'b0;
      if (quiet_left > 0) begin
        quiet_left--;
      end else if ($urandom_range(39) == 0) begin
        quiet_left = int'($urandom_range(30, 10));
      end else if ($urandom_range(5) == 0) begin
        k = int'($urandom_range(8));
        lvl_in[k] = ~lvl_in[k];
      end
      if (m_scene != 1 && $urandom_range(15) == 0) go = 1'b1;
      if ($urandom_range(299) == 0) rst = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
